// File: rtl/cswap_serial_loader.sv
// cswap_serial_loader: serial-to-parallel front end for the 12-bit Fredkin
// swap array. A frame is shifted in one bit at a time. The finished word is
// then held on word_out behind a valid/ready handshake. One completed word
// can wait in the shift register while the output slot is occupied.
// Optional macro CSWAP_LOADER_PARITY_EN appends an even-parity bit to each
// frame and enables the sticky parity_err flag.
module cswap_serial_loader #(
  parameter int WIDTH     = 12,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdi,
  input  logic             sdi_valid,
  input  logic             frame_start,
  input  logic             err_clr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

`ifdef CSWAP_LOADER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(FLEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PEND} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             vld_q, vld_d;
  logic             ferr_q, ferr_d;
`ifdef CSWAP_LOADER_PARITY_EN
  logic             perr_q, perr_d;
`endif
  logic             consume;
  logic             last_bit;
  logic             par_ok;
  logic [WIDTH-1:0] data_done;

  // Insert one serial bit according to the configured bit order
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r, input logic b);
    if (LSB_FIRST) return {b, r[WIDTH-1:1]};
    else           return {r[WIDTH-2:0], b};
  endfunction

  // Next-state logic for the frame FSM, output slot and sticky flags
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    vld_d     = vld_q;
    ferr_d    = ferr_q;
`ifdef CSWAP_LOADER_PARITY_EN
    perr_d    = perr_q;
    data_done = shreg_q;
    par_ok    = ((^shreg_q) == sdi);
`else
    data_done = shift_in(shreg_q, sdi);
    par_ok    = 1'b1;
`endif
    consume   = vld_q && word_ready;
    last_bit  = (cnt_q == CW'(FLEN - 1));

    if (consume) vld_d = 1'b0;
    // Clear first so an error raised in the same cycle wins
    if (err_clr) begin
      ferr_d = 1'b0;
`ifdef CSWAP_LOADER_PARITY_EN
      perr_d = 1'b0;
`endif
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
          if (sdi_valid) begin
            shreg_d = shift_in('0, sdi);
            cnt_d   = CW'(1);
          end
        end
      end
      SHIFT: begin
        if (frame_start) begin
          // Restart; abandoning a partly received frame is an error
          if (cnt_q != '0) ferr_d = 1'b1;
          shreg_d = '0;
          cnt_d   = '0;
          if (sdi_valid) begin
            shreg_d = shift_in('0, sdi);
            cnt_d   = CW'(1);
          end
        end else if (sdi_valid) begin
          if (!last_bit) begin
            shreg_d = shift_in(shreg_q, sdi);
            cnt_d   = cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
            if (!par_ok) begin
`ifdef CSWAP_LOADER_PARITY_EN
              perr_d = 1'b1;
`endif
              state_d = IDLE;
            end else if (!vld_q || consume) begin
              word_d  = data_done;
              vld_d   = 1'b1;
              state_d = IDLE;
            end else begin
              shreg_d = data_done;
              state_d = PEND;
            end
          end
        end
      end
      PEND: begin
        // Incoming traffic cannot be accepted while a word is parked
        if (sdi_valid || frame_start) ferr_d = 1'b1;
        if (consume) begin
          word_d  = shreg_q;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef CSWAP_LOADER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
`ifdef CSWAP_LOADER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign word_out   = word_q;
  assign word_valid = vld_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = ferr_q;
`ifdef CSWAP_LOADER_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_cswap_serial_loader.sv
// Directed bench for cswap_serial_loader. It runs an LSB-first and an
// MSB-first instance side by side on shared stimulus.
module tb_cswap_serial_loader;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sdi = 1'b0;
  logic sdi_valid = 1'b0;
  logic frame_start = 1'b0;
  logic err_clr = 1'b0;
  logic word_ready = 1'b0;

  logic [W-1:0] wo_l, wo_m;
  logic wv_l, wv_m, busy_l, busy_m, fe_l, fe_m, pe_l, pe_m;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  cswap_serial_loader #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_valid(sdi_valid),
    .frame_start(frame_start), .err_clr(err_clr), .word_out(wo_l),
    .word_valid(wv_l), .word_ready(word_ready), .busy(busy_l),
    .frame_err(fe_l), .parity_err(pe_l)
  );

  cswap_serial_loader #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_valid(sdi_valid),
    .frame_start(frame_start), .err_clr(err_clr), .word_out(wo_m),
    .word_valid(wv_m), .word_ready(word_ready), .busy(busy_m),
    .frame_err(fe_m), .parity_err(pe_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdi_valid = 1'b1;
    sdi = b;
    tick();
    sdi_valid = 1'b0;
    sdi = 1'b0;
  endtask

  task automatic start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_raw(input logic [W-1:0] w, input logic p);
    for (int i = 0; i < W; i++) send_bit(w[i]);
`ifdef CSWAP_LOADER_PARITY_EN
    send_bit(p);
`else
    if (p) begin end
`endif
  endtask

  task automatic send_data(input logic [W-1:0] w);
    send_raw(w, ^w);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_word_out", wo_l, 0);
    chk("rst_word_valid", wv_l, 0);
    chk("rst_busy", busy_l, 0);
    chk("rst_frame_err", fe_l, 0);
    chk("rst_parity_err", pe_l, 0);
    rst_n = 1'b1;
    tick();

    // sdi_valid in IDLE without frame_start is ignored
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("idle_ign_busy", busy_l, 0);
    chk("idle_ign_ferr", fe_l, 0);
    chk("idle_ign_valid", wv_l, 0);

    // T1: 0xA5C with ready=1, valid for one cycle
    word_ready = 1'b1;
    start();
    send_data(12'hA5C);
    chk("t1_word", wo_l, 12'hA5C);
    chk("t1_valid", wv_l, 1);
    chk("t1_ferr", fe_l, 0);
    chk("t1_busy", busy_l, 0);
    chk("t1_word_msb", wo_m, 12'h3A5);
    chk("t1_valid_msb", wv_m, 1);
    tick();
    chk("t1_valid_drop", wv_l, 0);
    chk("t1_word_hold", wo_l, 12'hA5C);
    chk("t1_valid_drop_msb", wv_m, 0);

    // T2: backpressure into PEND, then release
    word_ready = 1'b0;
    start();
    send_data(12'hA5C);
    chk("t2_first_valid", wv_l, 1);
    start();
    send_data(12'h3F0);
    chk("t2_pend_busy", busy_l, 1);
    chk("t2_pend_busy_msb", busy_m, 1);
    chk("t2_pend_word", wo_l, 12'hA5C);
    chk("t2_pend_valid", wv_l, 1);
    send_bit(1'b1);
    chk("t2_pend_drop_ferr", fe_l, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t2_errclr", fe_l, 0);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("t2_commit_word", wo_l, 12'h3F0);
    chk("t2_commit_valid", wv_l, 1);
    chk("t2_commit_busy", busy_l, 0);
    word_ready = 1'b1;
    tick();
    chk("t2_drain_valid", wv_l, 0);
    chk("t2_drain_hold", wo_l, 12'h3F0);

    // T4: frame_start coincident with the first bit
    frame_start = 1'b1;
    sdi_valid = 1'b1;
    sdi = 1'b1;
    tick();
    frame_start = 1'b0;
    sdi_valid = 1'b0;
    sdi = 1'b0;
    for (int i = 0; i < W - 1; i++) send_bit(1'b0);
`ifdef CSWAP_LOADER_PARITY_EN
    send_bit(1'b1);
`endif
    chk("t4_word_lsb", wo_l, 12'h001);
    chk("t4_word_msb", wo_m, 12'h800);
    chk("t4_ferr", fe_l, 0);

    // T3: aborted frame raises frame_err, following frame still loads
    start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    start();
    chk("t3_abort_ferr", fe_l, 1);
    chk("t3_abort_ferr_msb", fe_m, 1);
    chk("t3_abort_busy", busy_l, 1);
    send_data(12'h001);
    chk("t3_word", wo_l, 12'h001);
    chk("t3_valid", wv_l, 1);
    chk("t3_ferr_sticky", fe_l, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_errclr", fe_l, 0);
    chk("t3_consumed", wv_l, 0);

    // T5: asynchronous reset mid-frame
    word_ready = 1'b0;
    start();
    send_data(12'h5A5);
    chk("t5_pre_word", wo_l, 12'h5A5);
    start();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_word", wo_l, 0);
    chk("t5_rst_valid", wv_l, 0);
    chk("t5_rst_busy", busy_l, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    word_ready = 1'b1;
    start();
    send_data(12'hFFF);
    chk("t5_fff_word", wo_l, 12'hFFF);
    chk("t5_fff_valid", wv_l, 1);
    chk("t5_fff_word_msb", wo_m, 12'hFFF);
    tick();

`ifdef CSWAP_LOADER_PARITY_EN
    // Parity: mismatch discards, match commits
    start();
    send_raw(12'h00F, 1'b1);
    chk("par_bad_perr", pe_l, 1);
    chk("par_bad_word", wo_l, 12'hFFF);
    chk("par_bad_valid", wv_l, 0);
    chk("par_bad_busy", busy_l, 0);
    start();
    send_raw(12'h00F, 1'b0);
    chk("par_ok_word", wo_l, 12'h00F);
    chk("par_ok_valid", wv_l, 1);
    chk("par_ok_perr_msb", pe_m, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("par_errclr", pe_l, 0);
`else
    chk("nopar_perr", pe_l, 0);
    chk("nopar_perr_msb", pe_m, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cswap_serial_loader.md
Name: cswap_serial_loader

Overview:
- Serial-to-parallel front end that feeds the 12-bit controlled-swap (Fredkin) array.
- The array is organised as four groups of {control, a, b}.
- Shifts a frame in one bit at a time, then presents the completed word as a stable parallel vector with a valid/ready handshake.
- The 12 array input pins can therefore be driven from a narrow serial interface. Includes backpressure buffering and error flagging.

Parameters:
- WIDTH, 12, parallel word width; equals the swap-array input width.
- LSB_FIRST, 1, 1: first received bit lands in word bit 0; 0: first received bit lands in bit WIDTH-1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- sdi  in  1  serial data bit
- sdi_valid  in  1  sdi sampled when high
- frame_start  in  1  begins a new frame; aborts any partial frame
- err_clr  in  1  clears frame_err/parity_err
- word_out  out  WIDTH  parallel word to swap array
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  consumer accepts word when valid&&ready
- busy  out  1  high in SHIFT or PEND
- frame_err  out  1  sticky framing error
- parity_err  out  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert externally): state=IDLE, shift reg=0, bit count=0, word_out=0, word_valid=0, busy=0, frame_err=0, parity_err=0.
- FSM states: IDLE, SHIFT, PEND. busy=1 in SHIFT and PEND.
- IDLE:
  - frame_start -> SHIFT, count=0; shift reg cleared.
  - sdi_valid without frame_start: ignored, no error.
- SHIFT:
  - Each sdi_valid shifts sdi in per LSB_FIRST; count++.
  - On the edge sampling the last bit (count==FLEN-1; FLEN=WIDTH, or WIDTH+1 with parity), the word is complete.
  - Word complete and slot free (word_valid==0, or valid&&ready this same cycle): word_out loads the word, word_valid=1, -> IDLE. New word is visible the cycle after the last bit's edge.
  - Word complete and slot occupied: -> PEND, holding the word in the shift reg.
- PEND:
  - When the slot frees (valid&&ready): commit word_out on that same edge, word_valid stays 1, -> IDLE.
  - sdi_valid or frame_start in PEND: input dropped, frame_err=1.
- frame_start during SHIFT: restart (count=0, reg cleared), frame_err=1 if count>0.
- frame_start with sdi_valid in the same cycle (IDLE or SHIFT): that sdi is the first bit of the new frame; count=1.
- Handshake:
  - word_out stable while word_valid=1.
  - valid&&ready with no pending commit: word_valid=0 next cycle.
  - word_out retains the last value after consumption; the array stays driven.
  - word_valid never deasserts without ready.
- err_clr clears both sticky flags. If a new error occurs in the same cycle, set wins.
- Reset mid-frame or mid-PEND: all state discarded; word_out=0 immediately.

Optional Feature:
- Macro CSWAP_LOADER_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 bits; the last bit is even parity over the WIDTH data bits.
  - Match: normal commit.
  - Mismatch: word discarded (word_out/word_valid unchanged), parity_err=1, -> IDLE.
- Undefined: frame is WIDTH bits; parity_err tied 0.

Test Plan:
- Load 0xA5C LSB-first (bits 0,0,1,1,1,0,1,0,0,1,0,1), word_ready=1 -> word_out=0xA5C, word_valid=1 for exactly one cycle, one cycle after 12th bit edge; frame_err=0.
- word_ready=0; load 0xA5C then 0x3F0 -> after second frame state PEND, busy=1, word_out=0xA5C. Pulse ready one cycle -> word_out=0x3F0, word_valid=1, busy=0.
- frame_start, 5 bits, frame_start again, then 12 bits of 0x001 -> frame_err=1, word_out=0x001. err_clr -> frame_err=0.
- frame_start coincident with sdi_valid, sdi=1, then 11 zero bits -> word_out=0x001 (LSB_FIRST=1); with LSB_FIRST=0 -> 0x800.
- rst_n low after 7 bits of a frame -> word_out=0, word_valid=0, busy=0 asynchronously; next full frame 0xFFF loads correctly.
- With CSWAP_LOADER_PARITY_EN, send 0x00F with parity bit 1 -> parity_err=1, word_out unchanged. Same data with parity 0 -> word_out=0x00F.
